// File: rtl/riscv_multicycle_core_if.sv
// Bus between the multicycle core and its external instruction ROM / data RAM.
// The core drives addresses, store data and strobes; the memories return instr and dReadData.
interface riscv_multicycle_core_if;
  logic [31:0] instr;
  logic [31:0] dReadData;
  logic [31:0] PC;
  logic [31:0] dAddress;
  logic [31:0] dWriteData;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] WriteBackData;

  modport master (
    input  instr, dReadData,
    output PC, dAddress, dWriteData, MemRead, MemWrite, WriteBackData
  );

  modport slave (
    output instr, dReadData,
    input  PC, dAddress, dWriteData, MemRead, MemWrite, WriteBackData
  );
endinterface

// File: rtl/riscv_multicycle_core.sv
// Five-state (IF/ID/EX/MEM/WB) multicycle RV32I-subset core with PC, register file,
// immediate generator and ALU. Memories are external and reached through the bus interface.
module riscv_multicycle_core #(
  parameter logic [31:0] INITIAL_PC = 32'h0040_0000
) (
  input logic                      clk,
  input logic                      rst,
  riscv_multicycle_core_if.master  bus
);

  typedef enum logic [2:0] {S_IF, S_ID, S_EX, S_MEM, S_WB} state_t;
  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLT, ALU_SLL, ALU_SRL, ALU_SRA
  } alu_op_t;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] F7_Z   = 7'b0000000;
  localparam logic [6:0] F7_ALT = 7'b0100000;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [6:0]  op_q, f7_q;
  logic [2:0]  f3_q;
  logic [4:0]  rd_q;
  logic [31:0] a_q, b_q, imm_q, alu_q;
  logic        zero_q;
  logic [31:0] rf_q [32];

  alu_op_t     alu_op;
  logic        use_imm, rf_we, is_lw, is_sw, is_beq;
  logic        mem_read, mem_write;
  logic [31:0] rs1_val, rs2_val, op_b, alu_res, wb_data;

  function automatic logic [31:0] imm_gen(input logic [31:0] i);
    case (i[6:0])
      OP_SW:   imm_gen = {{20{i[31]}}, i[31:25], i[11:7]};
      OP_BEQ:  imm_gen = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      default: imm_gen = {{20{i[31]}}, i[31:20]};
    endcase
  endfunction

  function automatic logic [31:0] alu(input alu_op_t op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      ALU_SUB: alu = a - b;
      ALU_AND: alu = a & b;
      ALU_OR:  alu = a | b;
      ALU_XOR: alu = a ^ b;
      ALU_SLT: alu = {31'b0, ($signed(a) < $signed(b))};
      ALU_SLL: alu = a << b[4:0];
      ALU_SRL: alu = a >> b[4:0];
      ALU_SRA: alu = $unsigned($signed(a) >>> b[4:0]);
      default: alu = a + b;
    endcase
  endfunction

  // Register file read ports are addressed straight from the ROM word during ID.
  assign rs1_val = (bus.instr[19:15] == 5'd0) ? 32'd0 : rf_q[bus.instr[19:15]];
  assign rs2_val = (bus.instr[24:20] == 5'd0) ? 32'd0 : rf_q[bus.instr[24:20]];

  // Decode of the latched instruction; any unlisted opcode/funct pair falls through as a NOP.
  always_comb begin
    alu_op  = ALU_ADD;
    use_imm = 1'b0;
    rf_we   = 1'b0;
    is_lw   = 1'b0;
    is_sw   = 1'b0;
    is_beq  = 1'b0;
    case (op_q)
      OP_R: begin
        case (f3_q)
          3'b000: begin
            rf_we  = (f7_q == F7_Z) || (f7_q == F7_ALT);
            alu_op = (f7_q == F7_ALT) ? ALU_SUB : ALU_ADD;
          end
          3'b001: begin rf_we = (f7_q == F7_Z); alu_op = ALU_SLL; end
          3'b010: begin rf_we = (f7_q == F7_Z); alu_op = ALU_SLT; end
          3'b100: begin rf_we = (f7_q == F7_Z); alu_op = ALU_XOR; end
          3'b101: begin
            rf_we  = (f7_q == F7_Z) || (f7_q == F7_ALT);
            alu_op = (f7_q == F7_ALT) ? ALU_SRA : ALU_SRL;
          end
          3'b110: begin rf_we = (f7_q == F7_Z); alu_op = ALU_OR; end
          3'b111: begin rf_we = (f7_q == F7_Z); alu_op = ALU_AND; end
          default: ;
        endcase
      end
      OP_I: begin
        use_imm = 1'b1;
        case (f3_q)
          3'b000: begin rf_we = 1'b1; alu_op = ALU_ADD; end
          3'b001: begin rf_we = (f7_q == F7_Z); alu_op = ALU_SLL; end
          3'b010: begin rf_we = 1'b1; alu_op = ALU_SLT; end
          3'b100: begin rf_we = 1'b1; alu_op = ALU_XOR; end
          3'b101: begin
            rf_we  = (f7_q == F7_Z) || (f7_q == F7_ALT);
            alu_op = (f7_q == F7_ALT) ? ALU_SRA : ALU_SRL;
          end
          3'b110: begin rf_we = 1'b1; alu_op = ALU_OR; end
          3'b111: begin rf_we = 1'b1; alu_op = ALU_AND; end
          default: ;
        endcase
      end
      OP_LW: begin
        is_lw   = (f3_q == 3'b010);
        rf_we   = is_lw;
        use_imm = 1'b1;
      end
      OP_SW: begin
        is_sw   = (f3_q == 3'b010);
        use_imm = 1'b1;
      end
      OP_BEQ: begin
        is_beq = (f3_q == 3'b000);
        alu_op = ALU_SUB;
      end
      default: ;
    endcase
  end

  assign op_b    = use_imm ? imm_q : b_q;
  assign alu_res = alu(alu_op, a_q, op_b);
  assign wb_data = is_lw ? bus.dReadData : alu_q;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    case (state_q)
      S_IF:  state_d = S_ID;
      S_ID:  state_d = S_EX;
      S_EX:  state_d = S_MEM;
      S_MEM: begin
        mem_read  = is_lw;
        mem_write = is_sw;
        state_d   = S_WB;
      end
      S_WB: begin
        pc_d    = (is_beq && zero_q) ? pc_q + imm_q : pc_q + 32'd4;
        state_d = S_IF;
      end
      default: state_d = S_IF;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IF;
      pc_q    <= INITIAL_PC;
      op_q    <= '0;
      f7_q    <= '0;
      f3_q    <= '0;
      rd_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      imm_q   <= '0;
      alu_q   <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      if (state_q == S_ID) begin
        op_q  <= bus.instr[6:0];
        f3_q  <= bus.instr[14:12];
        f7_q  <= bus.instr[31:25];
        rd_q  <= bus.instr[11:7];
        a_q   <= rs1_val;
        b_q   <= rs2_val;
        imm_q <= imm_gen(bus.instr);
      end
      if (state_q == S_EX) begin
        alu_q  <= alu_res;
        zero_q <= (a_q - b_q) == 32'd0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else if (state_q == S_WB && rf_we && rd_q != 5'd0) begin
      rf_q[rd_q] <= wb_data;
    end
  end

  assign bus.PC            = pc_q;
  assign bus.dAddress      = alu_q;
  assign bus.dWriteData    = b_q;
  assign bus.MemRead       = mem_read;
  assign bus.MemWrite      = mem_write;
  assign bus.WriteBackData = wb_data;

endmodule

// File: tb/tb_riscv_multicycle_core.sv
// Directed bench for riscv_multicycle_core: a small ROM program plus a behavioural RAM,
// with hand-computed expectations checked in MEM, WB and the following IF of every instruction.
module tb_riscv_multicycle_core;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  riscv_multicycle_core_if bus();

  riscv_multicycle_core #(.INITIAL_PC(32'h0040_0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [31:0] rom [0:127];
  logic [31:0] ram [0:63];

  // Synchronous-read ROM and RAM with synchronous write and registered read.
  always @(posedge clk) begin
    bus.instr <= rom[bus.PC[8:2]];
    if (bus.MemWrite) ram[bus.dAddress[7:2]] <= bus.dWriteData;
    bus.dReadData <= ram[bus.dAddress[7:2]];
  end

  int total  = 0;
  int passed = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Runs one instruction starting in IF and ends in the next IF.
  task automatic exec(input string tag, input logic exp_rd, input logic exp_wr,
                      input logic chk_st, input logic [31:0] exp_addr, input logic [31:0] exp_wd,
                      input logic chk_wb, input logic [31:0] exp_wb, input logic [31:0] exp_pc);
    step(3);
    chk({tag, ".MemRead"},  {31'b0, bus.MemRead},  {31'b0, exp_rd});
    chk({tag, ".MemWrite"}, {31'b0, bus.MemWrite}, {31'b0, exp_wr});
    if (chk_st) begin
      chk({tag, ".dAddress"},   bus.dAddress,   exp_addr);
      chk({tag, ".dWriteData"}, bus.dWriteData, exp_wd);
    end
    step(1);
    chk({tag, ".wb_strobes"}, {30'b0, bus.MemRead, bus.MemWrite}, 32'd0);
    if (chk_wb) chk({tag, ".WriteBackData"}, bus.WriteBackData, exp_wb);
    step(1);
    chk({tag, ".PC"}, bus.PC, exp_pc);
  endtask

  initial begin
    for (int i = 0; i < 128; i++) rom[i] = 32'h0000_0013;
    rom[0]  = 32'h0050_0093; // addi x1,x0,5
    rom[1]  = 32'hFFD0_0113; // addi x2,x0,-3
    rom[2]  = 32'h0020_81B3; // add  x3,x1,x2
    rom[3]  = 32'h4020_8233; // sub  x4,x1,x2
    rom[4]  = 32'h0010_2423; // sw   x1,8(x0)
    rom[5]  = 32'h0080_2283; // lw   x5,8(x0)
    rom[6]  = 32'h0010_8663; // beq  x1,x1,+12
    rom[7]  = 32'h0630_0513; // addi x10,x0,99 (skipped)
    rom[8]  = 32'h0630_0513; // addi x10,x0,99 (skipped)
    rom[9]  = 32'h0020_8663; // beq  x1,x2,+12
    rom[10] = 32'h4011_5313; // srai x6,x2,1
    rom[11] = 32'h01C1_5393; // srli x7,x2,28
    rom[12] = 32'h0011_2433; // slt  x8,x2,x1
    rom[13] = 32'h0070_0013; // addi x0,x0,7
    rom[14] = 32'h0000_04B3; // add  x9,x0,x0
    rom[15] = 32'hFFFF_FFFF; // undefined opcode
    rom[16] = 32'h000F_8633; // add  x12,x31,x0
    rom[17] = 32'h0005_06B3; // add  x13,x10,x0
    rom[18] = 32'h0020_C733; // xor  x14,x1,x2

    rst = 1'b1;
    #1;
    chk("rst.PC",       bus.PC, 32'h0040_0000);
    chk("rst.MemRead",  {31'b0, bus.MemRead},  32'd0);
    chk("rst.MemWrite", {31'b0, bus.MemWrite}, 32'd0);
    step(2);
    rst = 1'b0;

    exec("addi_x1", 0, 0, 0, 0, 0, 1, 32'h0000_0005, 32'h0040_0004);
    exec("addi_x2", 0, 0, 0, 0, 0, 1, 32'hFFFF_FFFD, 32'h0040_0008);
    exec("add_x3",  0, 0, 0, 0, 0, 1, 32'h0000_0002, 32'h0040_000C);
    exec("sub_x4",  0, 0, 0, 0, 0, 1, 32'h0000_0008, 32'h0040_0010);
    exec("sw",      0, 1, 1, 32'h0000_0008, 32'h0000_0005, 0, 0, 32'h0040_0014);
    exec("lw",      1, 0, 0, 0, 0, 1, 32'h0000_0005, 32'h0040_0018);
    exec("beq_tk",  0, 0, 0, 0, 0, 0, 0, 32'h0040_0024);
    exec("beq_nt",  0, 0, 0, 0, 0, 0, 0, 32'h0040_0028);
    exec("srai",    0, 0, 0, 0, 0, 1, 32'hFFFF_FFFE, 32'h0040_002C);
    exec("srli",    0, 0, 0, 0, 0, 1, 32'h0000_000F, 32'h0040_0030);
    exec("slt",     0, 0, 0, 0, 0, 1, 32'h0000_0001, 32'h0040_0034);
    exec("addi_x0", 0, 0, 0, 0, 0, 0, 0, 32'h0040_0038);
    exec("add_x9",  0, 0, 0, 0, 0, 1, 32'h0000_0000, 32'h0040_003C);
    exec("undef",   0, 0, 0, 0, 0, 0, 0, 32'h0040_0040);
    exec("x31_kept",0, 0, 0, 0, 0, 1, 32'h0000_0000, 32'h0040_0044);
    exec("x10_kept",0, 0, 0, 0, 0, 1, 32'h0000_0000, 32'h0040_0048);
    exec("xor",     0, 0, 0, 0, 0, 1, 32'hFFFF_FFF8, 32'h0040_004C);

    // Reset asserted while the next instruction is in EX.
    step(2);
    rst = 1'b1;
    #1;
    chk("midrst.PC",       bus.PC, 32'h0040_0000);
    chk("midrst.MemRead",  {31'b0, bus.MemRead},  32'd0);
    chk("midrst.MemWrite", {31'b0, bus.MemWrite}, 32'd0);
    step(1);
    chk("midrst.PC_hold", bus.PC, 32'h0040_0000);
    rst = 1'b0;
    exec("restart", 0, 0, 0, 0, 0, 1, 32'h0000_0005, 32'h0040_0004);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/riscv_multicycle_core.md
Name: riscv_multicycle_core

Overview:
- Five-state multicycle RV32I-subset processor core.
- Fetches from an external synchronous-read instruction ROM and accesses an external data RAM with synchronous write and registered read.
- Contains the PC, control FSM, 32x32 register file, immediate generator and ALU.
- Top-level compute block of the CPU; the memories sit outside it and connect through the ports below.

Parameters:
- INITIAL_PC, 32'h0040_0000, PC value loaded on reset.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- instr  in  32  instruction word returned by the ROM for the current PC.
- dReadData  in  32  data word returned by the RAM.
- PC  out  32  program counter; the ROM is addressed with PC[8:0].
- dAddress  out  32  data memory byte address (ALU result register).
- dWriteData  out  32  store data (rs2 value).
- MemRead  out  1  high in the MEM state of a load.
- MemWrite  out  1  high in the MEM state of a store.
- WriteBackData  out  32  value written to rd: dReadData for LW, ALU result otherwise.

Behaviour:
- Reset (asynchronous, any cycle, including mid-instruction):
  - PC=INITIAL_PC, FSM=IF.
  - All 32 registers, ALU result register and operand registers cleared to 0.
  - MemRead=MemWrite=0.
  - Execution resumes from IF on the first rising edge after rst falls.
- FSM: IF -> ID -> EX -> MEM -> WB -> IF, one state per clock. Every instruction takes exactly 5 cycles; unused states are idle.
  - IF: PC drives the ROM address (ROM latches it on this edge).
  - ID: sample instr. Read rs1=instr[19:15] and rs2=instr[24:20] into operand registers. Build the immediate:
    - I-type: sign-extended [31:20].
    - S-type: {[31:25],[11:7]}.
    - B-type: {[31],[7],[30:25],[11:8],0}, sign-extended.
  - EX: ALU computes and its result is registered (drives dAddress). Zero flag is registered for BEQ.
  - MEM: MemRead=1 for LW, MemWrite=1 for SW; both are 0 in all other states and instructions.
  - WB: write rd=instr[11:7] with WriteBackData for R-type, I-ALU and LW. Then update PC: PC+imm_B if BEQ and Zero, else PC+4.
- Supported instructions:
  - R-type (0110011): ADD, SUB, AND, OR, XOR, SLT, SLL, SRL, SRA.
  - I-ALU (0010011): ADDI, ANDI, ORI, XORI, SLTI, SLLI, SRLI, SRAI.
  - LW (0000011), SW (0100011), BEQ (1100011).
- Any other opcode or funct combination executes as a NOP: no register write, no memory access, PC+4.
- ALU rules:
  - 32-bit wrap-around arithmetic.
  - Shift amount = operand B[4:0]; SRA/SRAI are arithmetic.
  - SLT/SLTI compare signed, result 0 or 1.
  - LW/SW address = rs1 + sign-extended immediate.
  - BEQ compares rs1 - rs2 == 0.
- Register file:
  - x0 always reads 0; writes to x0 are ignored.
  - Combinational read; write on the rising edge in WB only.
- WriteBackData is combinational and valid during WB. dWriteData holds rs2 from ID through MEM.
- Branch target uses the PC of the branch itself. The PC increments wrap modulo 2^32.

Test Plan:
- Reset: hold rst=1 mid-EX -> PC=0x0040_0000, MemRead=MemWrite=0 immediately; the first fetch after release is at 0x0040_0000 and PC=0x0040_0004 after 5 cycles.
- ADDI x1,x0,5; ADDI x2,x0,-3; ADD x3,x1,x2; SUB x4,x1,x2 -> WriteBackData 5, 0xFFFFFFFD, 2, 8 in successive WB states.
- SW x1,8(x0); LW x5,8(x0) -> MemWrite=1 for one cycle with dAddress=8, dWriteData=5; LW has MemRead=1 and WriteBackData=5.
- BEQ x1,x1,+12 -> PC advances by 12; BEQ x1,x2,+12 -> PC advances by 4.
- SRAI x6,x2,1 -> 0xFFFFFFFE; SRLI x7,x2,28 -> 0xF; SLT x8,x2,x1 -> 1.
- ADDI x0,x0,7 then ADD x9,x0,x0 -> x9=0. An undefined opcode leaves all registers unchanged and advances PC by 4.
